// File: rtl/adc_sim_multi.sv
// adc_sim_multi: behavioural stand-in for the Mercury2 on-board SPI ADC.
// It keeps the trigger/channel/Dout/OutVal handshake, so client logic does
// not change when the real converter interface is swapped in.
// Each channel has its own stimulus generator (ramp, hold, triangle or
// channel-ID pattern). Results can be single-ended or differential against
// the partner channel (ch ^ 1).
//
// Ports:
//   clock, reset   system clock; synchronous active-high reset
//   trigger        starts a conversion; only sampled while idle
//   channel        channel select, latched when a trigger is accepted
//   diffn          1 = single-ended, 0 = differential (latched)
//   mode           generator mode, latched: 0 ramp, 1 hold, 2 triangle, 3 ID
//   Dout           registered conversion result
//   OutVal         high while idle; Dout is stable and valid then
//   overrun        one-cycle pulse for each trigger seen while busy
//   adc_*          SPI pins; the outputs are tied to idle constants
module adc_sim_multi #(
  parameter int DATA_WIDTH   = 10,
  parameter int NUM_CHANNELS = 8,
  parameter int CHAN_WIDTH   = 3,
  parameter int CONV_DELAY   = 10,
  parameter int START_VALUE  = 512,
  parameter int STEP         = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [CHAN_WIDTH-1:0] channel,
  input  logic                  diffn,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  OutVal,
  output logic                  overrun,
  input  logic                  adc_miso,
  output logic                  adc_mosi,
  output logic                  adc_cs,
  output logic                  adc_clk
);

  localparam int W = DATA_WIDTH;
  localparam int CNT_W = (CONV_DELAY < 1) ? 1 : $clog2(CONV_DELAY + 1);
  localparam logic [W-1:0] STEP_W  = W'(STEP);
  localparam logic [W-1:0] START_W = W'(START_VALUE);
  localparam logic [W-1:0] HALF_W  = W'(1) << (W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    CONVERT = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      counter_reg;
  logic [CHAN_WIDTH-1:0] chan_reg;
  logic                  diffn_reg;
  logic [1:0]            mode_reg;
  logic [W-1:0]          result_reg;
  logic [W-1:0]          dout_reg;
  logic                  overrun_reg;
  logic                  accept;
  logic                  conv_done;

  // Current value of every channel generator.
  logic [NUM_CHANNELS-1:0][W-1:0] gen_bus;

  // The SPI pins are never exercised.
  logic unused_miso;
  assign unused_miso = adc_miso;
  assign adc_mosi    = 1'b0;
  assign adc_cs      = 1'b0;
  assign adc_clk     = 1'b0;

  assign accept    = (state_reg == IDLE) && trigger;
  assign conv_done = (state_reg == CONVERT) && (counter_reg == '0);

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trigger) state_next = LATCH;
      LATCH:   state_next = CONVERT;
      CONVERT: if (counter_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      chan_reg    <= '0;
      diffn_reg   <= 1'b1;
      mode_reg    <= 2'd0;
      result_reg  <= '0;
      dout_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      overrun_reg <= trigger && (state_reg != IDLE);
      if (accept) begin
        chan_reg  <= channel;
        diffn_reg <= diffn;
        mode_reg  <= mode;
      end
      if (state_reg == LATCH) begin
        counter_reg <= CNT_W'(CONV_DELAY);
        // The generator advanced on the accepting edge, so the result can
        // be formed here. Nothing else can touch the generators until the
        // conversion ends.
        if (mode_reg == 2'd3) begin
          result_reg <= {chan_reg, {(W - CHAN_WIDTH){1'b0}}};
        end else if (diffn_reg) begin
          result_reg <= gen_bus[chan_reg];
        end else begin
          result_reg <= gen_bus[chan_reg] - gen_bus[chan_reg ^ CHAN_WIDTH'(1)] + HALF_W;
        end
      end else if ((state_reg == CONVERT) && (counter_reg != '0)) begin
        counter_reg <= counter_reg - CNT_W'(1);
      end
      if (conv_done) dout_reg <= result_reg;
    end
  end

  assign Dout    = dout_reg;
  assign OutVal  = (state_reg == IDLE);
  assign overrun = overrun_reg;

  // One independent generator per channel. Each advances only when a
  // trigger for its own channel is accepted.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    logic [W-1:0] gen_reg;
    logic         down_reg;
    logic [W:0]   sum_up;

    // The extra top bit flags that gen+STEP has passed the full-scale code.
    assign sum_up      = {1'b0, gen_reg} + {1'b0, STEP_W};
    assign gen_bus[gi] = gen_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        gen_reg  <= START_W;
        down_reg <= 1'b0;
      end else if (accept && (channel == CHAN_WIDTH'(gi))) begin
        case (mode)
          2'd0: gen_reg <= sum_up[W-1:0];
          2'd2: begin
            if (!down_reg) begin
              if (sum_up[W]) begin
                gen_reg  <= gen_reg - STEP_W;
                down_reg <= 1'b1;
              end else begin
                gen_reg <= sum_up[W-1:0];
              end
            end else begin
              if (gen_reg < STEP_W) begin
                gen_reg  <= sum_up[W-1:0];
                down_reg <= 1'b0;
              end else begin
                gen_reg <= gen_reg - STEP_W;
              end
            end
          end
          default: gen_reg <= gen_reg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sim_multi.sv
// tb_adc_sim_multi: self-checking bench for adc_sim_multi.
// Two instances share the stimulus: one with STEP=1 and one with STEP=256,
// so the triangle reversals at both ends of the range show up in a few
// conversions. A reference model tracks every channel's generator with
// plain integer arithmetic modulo 1024.
module tb_adc_sim_multi;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [2:0] channel = 3'd0;
  logic       diffn = 1'b1;
  logic [1:0] mode = 2'd0;

  logic [9:0] dout_a, dout_b;
  logic       outval_a, outval_b, overrun_a, overrun_b;
  logic       mosi_a, cs_a, sclk_a, mosi_b, cs_b, sclk_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: index 0 is the STEP=1 instance, index 1 is the
  // STEP=256 instance.
  int gen_m [2][8];
  bit down_m[2][8];
  int step_m[2] = '{1, 256};
  int exp_a = 0;
  int exp_b = 0;

  always #10 clock = ~clock;

  adc_sim_multi #(.STEP(1)) u_dut_a (
    .clock(clock), .reset(reset), .trigger(trigger), .channel(channel),
    .diffn(diffn), .mode(mode), .Dout(dout_a), .OutVal(outval_a),
    .overrun(overrun_a), .adc_miso(1'b0), .adc_mosi(mosi_a),
    .adc_cs(cs_a), .adc_clk(sclk_a)
  );

  adc_sim_multi #(.STEP(256)) u_dut_b (
    .clock(clock), .reset(reset), .trigger(trigger), .channel(channel),
    .diffn(diffn), .mode(mode), .Dout(dout_b), .OutVal(outval_b),
    .overrun(overrun_b), .adc_miso(1'b0), .adc_mosi(mosi_b),
    .adc_cs(cs_b), .adc_clk(sclk_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        gen_m[k][i]  = 512;
        down_m[k][i] = 1'b0;
      end
    end
    exp_a = 0;
    exp_b = 0;
  endtask

  // Advance the selected generator and return the result each instance
  // should deliver at the end of this conversion.
  task automatic model_conv(input int ch, input int d, input int m,
                            output int ra, output int rb);
    int r [2];
    for (int k = 0; k < 2; k++) begin
      int s = step_m[k];
      int g = gen_m[k][ch];
      if (m == 0) begin
        g = (g + s) % 1024;
      end else if (m == 2) begin
        if (!down_m[k][ch]) begin
          if (g + s > 1023) begin g = g - s; down_m[k][ch] = 1'b1; end
          else g = g + s;
        end else begin
          if (g < s) begin g = g + s; down_m[k][ch] = 1'b0; end
          else g = g - s;
        end
      end
      gen_m[k][ch] = g;
      if (m == 3)      r[k] = ch * 128;
      else if (d == 1) r[k] = g;
      else             r[k] = ((g - gen_m[k][ch ^ 1] + 512) % 1024 + 1024) % 1024;
    end
    ra = r[0];
    rb = r[1];
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    trigger = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One single-cycle trigger followed by a full conversion check.
  task automatic do_conv(input int ch, input int d, input int m);
    int ra, rb, busy;
    @(negedge clock);
    channel = 3'(ch);
    diffn   = d[0];
    mode    = 2'(m);
    trigger = 1'b1;
    model_conv(ch, d, m, ra, rb);
    @(negedge clock);
    trigger = 1'b0;
    check("dout_a_hold", 32'(dout_a), exp_a);
    busy = 0;
    while (outval_a !== 1'b1 && busy < 200) begin
      busy++;
      @(negedge clock);
    end
    exp_a = ra;
    exp_b = rb;
    $display("conv ch=%0d diffn=%0d mode=%0d: busy=%0d dout_a=%0d (exp %0d) dout_b=%0d (exp %0d)",
             ch, d, m, busy, dout_a, exp_a, dout_b, exp_b);
    check("busy_len", busy, 12);
    check("dout_a", 32'(dout_a), exp_a);
    check("dout_b", 32'(dout_b), exp_b);
    check("outval_b", 32'(outval_b), 1);
    check("overrun_a_idle", 32'(overrun_a), 0);
  endtask

  initial begin
    int pa, pb;
    int busy;

    // Reset state.
    model_reset();
    do_reset();
    check("rst_outval", 32'(outval_a), 1);
    check("rst_dout", 32'(dout_a), 0);
    check("rst_overrun", 32'(overrun_a), 0);
    check("rst_dout_b", 32'(dout_b), 0);
    check("spi_pins", {29'd0, mosi_a, cs_a, sclk_a}, 0);

    // Basic ramp on ch0, then independent generators on ch2 and ch5.
    do_conv(0, 1, 0);
    do_conv(0, 1, 0);
    do_conv(2, 1, 0);
    do_conv(2, 1, 0);
    do_conv(2, 1, 0);
    do_conv(5, 1, 0);

    // Trigger held high for 40 cycles: a conversion every 13 cycles and an
    // overrun pulse after every busy cycle.
    @(negedge clock);
    channel = 3'd0; diffn = 1'b1; mode = 2'd0; trigger = 1'b1;
    pa = 0; pb = 0;
    for (int j = 0; j < 40; j++) begin
      if (j % 13 == 0) model_conv(0, 1, 0, pa, pb);
      @(negedge clock);
      if (j % 13 == 12) begin exp_a = pa; exp_b = pb; end
      check("held_outval", 32'(outval_a), (j % 13 == 12) ? 1 : 0);
      check("held_overrun", 32'(overrun_a), (j % 13 != 0) ? 1 : 0);
      check("held_dout", 32'(dout_a), exp_a);
    end
    $display("held trigger: last dout_a=%0d dout_b=%0d", dout_a, dout_b);
    trigger = 1'b0;
    busy = 0;
    while (outval_a !== 1'b1 && busy < 200) begin
      busy++;
      @(negedge clock);
    end
    exp_a = pa; exp_b = pb;
    check("held_tail_dout_a", 32'(dout_a), exp_a);
    check("held_tail_dout_b", 32'(dout_b), exp_b);

    // Differential: ch1 ramped to 520, ch0 converted differentially.
    do_reset();
    for (int n = 0; n < 8; n++) do_conv(1, 1, 0);
    do_conv(0, 0, 0);
    check("diff_505", 32'(dout_a), 505);

    // Triangle on ch3; the STEP=256 instance reverses at both limits.
    for (int n = 0; n < 5; n++) do_conv(3, 1, 2);
    check("tri_bottom_b", 32'(dout_b), 256);

    // Channel-ID pattern.
    do_conv(6, 0, 3);
    check("id_768", 32'(dout_a), 768);

    // Reset during the fifth busy cycle aborts the conversion.
    @(negedge clock);
    channel = 3'd0; diffn = 1'b1; mode = 2'd0; trigger = 1'b1;
    @(negedge clock);
    trigger = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_busy", 32'(outval_a), 0);
    check("abort_dout_hold", 32'(dout_a), 768);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    $display("reset mid-conversion: outval_a=%0d dout_a=%0d", outval_a, dout_a);
    check("abort_outval", 32'(outval_a), 1);
    check("abort_dout", 32'(dout_a), 0);
    do_conv(0, 1, 0);
    check("after_abort_513", 32'(dout_a), 513);

    // Randomized conversions against the model.
    for (int n = 0; n < 60; n++) begin
      do_conv(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_sim_multi.md
Name: adc_sim_multi

Overview:
- Parametrised behavioural stand-in for the Mercury2 on-board SPI ADC, used in simulation and bring-up builds instead of the real converter interface.
- Keeps the same trigger/channel/Dout/OutVal handshake, so the ADC interface can be swapped without touching client logic.
- Adds configurable width, channel count and conversion delay.
- Adds per-channel stimulus generators with selectable waveform mode, a differential mode, and overrun detection.
- SPI pins are driven to idle constants.

Parameters:
DATA_WIDTH, 10, sample width in bits (W)
NUM_CHANNELS, 8, number of channels; must be a power of 2, at least 2
CHAN_WIDTH, 3, log2(NUM_CHANNELS)
CONV_DELAY, 10, busy-phase count; OutVal stays low for CONV_DELAY+2 cycles
START_VALUE, 512, reset value of every channel generator
STEP, 1, generator increment per conversion; must be >0 and <2^(W-1)

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
trigger  input  1  start a conversion; sampled only in IDLE
channel  input  CHAN_WIDTH  channel select, latched on accepted trigger
diffn  input  1  1 = single-ended, 0 = differential; latched on accepted trigger
mode  input  2  generator mode, latched on accepted trigger
Dout  output  DATA_WIDTH  registered conversion result
OutVal  output  1  high when idle and Dout valid
overrun  output  1  one-cycle pulse when trigger arrives while busy
adc_miso  input  1  unused
adc_mosi  output  1  constant 0
adc_cs  output  1  constant 0
adc_clk  output  1  constant 0

Behaviour:
- Reset (synchronous, active-high):
  - State=IDLE, OutVal=1, Dout=0, overrun=0, counter=0.
  - Every gen[i]=START_VALUE and every dir[i]=up.
  - Reset mid-conversion aborts the conversion; no Dout update.
- States: IDLE -> LATCH -> CONVERT -> IDLE. Any illegal encoding goes to IDLE.
- IDLE, trigger=1 at edge T:
  - Latch channel, diffn and mode.
  - Advance gen[channel] per mode.
  - Go to LATCH.
- LATCH: counter<=CONV_DELAY; go to CONVERT.
- CONVERT:
  - counter<=counter-1 each cycle.
  - When counter==0: Dout<=result and State<=IDLE, on the same edge.
- OutVal:
  - Combinational: OutVal = (State==IDLE).
  - Goes low after edge T and high again after edge T+CONV_DELAY+2, i.e. low for CONV_DELAY+2 cycles.
  - Dout is constant whenever OutVal=1.
- Trigger while not IDLE: ignored, no queueing. overrun=1 for the next cycle. A held trigger produces an overrun pulse every busy cycle.
- Trigger held high into IDLE starts a new conversion on that edge, so back-to-back conversions have exactly 1 idle cycle between them.
- Generator modes (mode latched; all arithmetic mod 2^W):
  - 0 ramp: gen<=gen+STEP, wrapping.
  - 1 hold: gen unchanged.
  - 2 triangle:
    - If dir up: gen+STEP > 2^W-1 gives gen<=gen-STEP, dir<=down; otherwise gen<=gen+STEP.
    - If dir down: gen < STEP gives gen<=gen+STEP, dir<=up; otherwise gen<=gen-STEP.
  - 3 channel ID: gen unchanged; result is the pattern latched_channel * (2^W/NUM_CHANNELS).
- Result:
  - Single-ended: result = gen[ch] after advance (modes 0-2), or the ID pattern (mode 3).
  - Differential (diffn=0, modes 0-2): result = (gen[ch] - gen[ch^1] + 2^(W-1)) mod 2^W.
    - gen[ch] is the advanced value; the partner ch^1 is not advanced.
    - Mode 3 ignores diffn.
- Each channel's generator state persists independently between conversions.

Test Plan:
- Reset, then trigger 1 cycle on ch0, mode 0, diffn=1 -> OutVal low exactly 12 cycles, then Dout=513, OutVal=1; second trigger gives Dout=514.
- Trigger ch2 mode 0 three times, then ch5 once -> ch2 results 513, 514, 515; ch5 result 513 (independent generators).
- Hold trigger high for 40 cycles, ch0 mode 0 -> conversions every 13 cycles; overrun pulses on every busy cycle; Dout increments by 1 per conversion.
- Run ch1 mode 0 to 520, then convert ch0 with diffn=0 -> Dout = (513-520+512) = 505.
- Mode 2 with STEP=256, ch3 -> 768, then 512 (reverses at 1023 limit), then 256, 0, then 256 (reverses at bottom).
- Mode 3 on ch6 -> Dout=768. Reset asserted on the 5th busy cycle -> OutVal=1, Dout=0 next cycle; next ch0 conversion gives 513.
